// File: rtl/io_rle_unpacker.sv
// io_rle_unpacker: expands packed {bit, run_length} tokens from bus words into
// a bit FIFO and serves variable-length fields, zero- or sign-extended, on
// request. The oldest bit in the FIFO becomes the MSB of the extracted field.
module io_rle_unpacker #(
  parameter int DATA_W  = 32,
  parameter int RUN_W   = 3,
  parameter int BUF_W   = 128,
  parameter int FIELD_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [DATA_W-1:0]            in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         req_valid,
  input  logic [$clog2(FIELD_W+1)-1:0] req_len,
  input  logic                         req_signed,
  output logic                         req_ready,
  output logic [FIELD_W-1:0]           out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(BUF_W+1)-1:0]   fill,
  output logic                         err_len
);

  localparam int TOK_W  = 1 + RUN_W;
  localparam int NTOK   = DATA_W / TOK_W;
  localparam int LEN_W  = $clog2(FIELD_W + 1);
  localparam int FILL_W = $clog2(BUF_W + 1);
  localparam int IDX_W  = (NTOK > 1) ? $clog2(NTOK) : 1;
  localparam logic [BUF_W-1:0] BUF_ONE = BUF_W'(1'b1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

  // Valid bits live in buf_r[fill_r-1:0]; bit fill_r-1 is the oldest.
  logic [BUF_W-1:0]   buf_r;
  logic [FILL_W-1:0]  fill_r;
  logic [FILL_W-1:0]  fill_next_s;
  logic [DATA_W-1:0]  hold_data_r;
  logic               hold_valid_r;
  logic [IDX_W-1:0]   tok_idx_r;
  state_t             state_r;
  state_t             state_s;
  logic [LEN_W-1:0]   len_r;
  logic               sgn_r;
  logic [FIELD_W-1:0] out_data_r;
  logic               out_valid_r;
  logic               err_len_r;

  logic               tok_bit_s;
  logic [RUN_W-1:0]   tok_run_s;
  logic               room_s;
  logic               tok_go_s;
  logic               tok_last_s;
  logic               load_s;
  logic [BUF_W-1:0]   app_bits_s;
  logic               ext_go_s;
  logic               illegal_s;
  logic               accept_s;
  logic [FIELD_W-1:0] raw_s;
  logic [FIELD_W-1:0] field_s;

  // Right-aligned raw field of length len; upper bits take the field MSB when
  // sign-extending, zero otherwise.
  function automatic logic [FIELD_W-1:0] extend_field(
    input logic [FIELD_W-1:0] raw,
    input logic [LEN_W-1:0]   len,
    input logic               sgn
  );
    logic [FIELD_W-1:0] res;
    logic               msb;
    msb = 1'b0;
    res = {FIELD_W{1'b0}};
    for (int i = 0; i < FIELD_W; i++) begin
      if (LEN_W'(i + 1) == len) msb = raw[i];
    end
    for (int i = 0; i < FIELD_W; i++) begin
      if (LEN_W'(i) < len) res[i] = raw[i];
      else                 res[i] = sgn & msb;
    end
    return res;
  endfunction

  // Current token decode, buffer-room test and input handshake
  always_comb begin
    tok_bit_s  = hold_data_r[DATA_W-1];
    tok_run_s  = hold_data_r[DATA_W-2 -: RUN_W];
    room_s     = ({1'b0, fill_r} + (FILL_W+1)'(tok_run_s)) <= (FILL_W+1)'(BUF_W);
    tok_go_s   = hold_valid_r & room_s;
    tok_last_s = tok_go_s & (tok_idx_r == IDX_W'(NTOK - 1));
    in_ready   = ~hold_valid_r | tok_last_s;
    load_s     = in_valid & in_ready;
    if (tok_bit_s) app_bits_s = (BUF_ONE << tok_run_s) - BUF_ONE;
    else           app_bits_s = {BUF_W{1'b0}};
  end

  // Extraction datapath: the len oldest bits come from pre-cycle contents
  always_comb begin
    ext_go_s    = (state_r == ST_WAIT) && (fill_r >= FILL_W'(len_r));
    raw_s       = FIELD_W'(buf_r >> (fill_r - FILL_W'(len_r)));
    field_s     = extend_field(raw_s, len_r, sgn_r);
    illegal_s   = (req_len == {LEN_W{1'b0}}) || (req_len > LEN_W'(FIELD_W));
    fill_next_s = fill_r;
    if (tok_go_s) fill_next_s = fill_next_s + FILL_W'(tok_run_s);
    else          fill_next_s = fill_next_s;
    if (ext_go_s) fill_next_s = fill_next_s - FILL_W'(len_r);
    else          fill_next_s = fill_next_s;
  end

  // Hold register: load a new word or advance to the next token once appended
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      hold_valid_r <= 1'b0;
      hold_data_r  <= {DATA_W{1'b0}};
      tok_idx_r    <= {IDX_W{1'b0}};
    end else if (load_s) begin
      hold_valid_r <= 1'b1;
      hold_data_r  <= in_data;
      tok_idx_r    <= {IDX_W{1'b0}};
    end else if (tok_go_s) begin
      hold_valid_r <= ~tok_last_s;
      hold_data_r  <= hold_data_r << TOK_W;
      tok_idx_r    <= tok_idx_r + IDX_W'(1'b1);
    end
  end

  // Bit buffer: new bits shift in behind existing ones; extraction only moves fill
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      buf_r  <= {BUF_W{1'b0}};
      fill_r <= {FILL_W{1'b0}};
    end else begin
      if (tok_go_s) buf_r <= (buf_r << tok_run_s) | app_bits_s;
      fill_r <= fill_next_s;
    end
  end

  // Extractor state register
  always_ff @(posedge clk) begin
    if (rst || flush) state_r <= ST_IDLE;
    else              state_r <= state_s;
  end

  // Extractor next state and request handshake
  always_comb begin
    state_s   = state_r;
    req_ready = 1'b0;
    accept_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid && !illegal_s) begin
          accept_s = 1'b1;
          state_s  = ST_WAIT;
        end else begin
          state_s  = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (ext_go_s) state_s = ST_VALID;
        else          state_s = ST_WAIT;
      end
      ST_VALID: begin
        if (out_ready) state_s = ST_IDLE;
        else           state_s = ST_VALID;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Request latch, registered output field, valid flag and length-error pulse
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      len_r       <= {LEN_W{1'b0}};
      sgn_r       <= 1'b0;
      out_data_r  <= {FIELD_W{1'b0}};
      out_valid_r <= 1'b0;
      err_len_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        len_r <= req_len;
        sgn_r <= req_signed;
      end
      if (ext_go_s) out_data_r <= field_s;
      out_valid_r <= (state_s == ST_VALID);
      err_len_r   <= req_ready & req_valid & illegal_s;
    end
  end

  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign fill      = fill_r;
  assign err_len   = err_len_r;

endmodule

// File: doc/io_rle_unpacker.md
Name: io_rle_unpacker

Overview:
- Parametrised run-length input unpacker for the solver IO path.
- Accepts bus words of packed {bit, run_length} tokens through a valid/ready handshake and expands them into a bit FIFO.
- Delivers variable-length fields, zero- or sign-extended, on request to the downstream RAM-load sequencer.
- Adds over the previous IO decoder: generic widths, input and output backpressure, explicit buffer-full stall, flush, and length-error reporting.

Parameters:
- DATA_W, 32: input word width; must be a multiple of TOK_W.
- RUN_W, 3: run-length field width per token. TOK_W = 1+RUN_W, NTOK = DATA_W/TOK_W.
- BUF_W, 128: bit-buffer capacity; must satisfy BUF_W >= FIELD_W + 2^RUN_W - 1.
- FIELD_W, 16: maximum field length and output width.

Ports:
- clk, in, 1: clock; all logic on posedge.
- rst, in, 1: synchronous active-high reset.
- flush, in, 1: synchronous clear of buffer, hold word and pending request.
- in_data, in, DATA_W: packed token word. Token 0 is at [DATA_W-1 -: TOK_W]; token MSB is the bit value, the lower RUN_W bits are the run length.
- in_valid, in, 1: in_data valid.
- in_ready, out, 1: unpacker accepts the word this cycle.
- req_valid, in, 1: field request.
- req_len, in, $clog2(FIELD_W+1): requested field length, 1..FIELD_W.
- req_signed, in, 1: 1 = sign-extend, 0 = zero-extend.
- req_ready, out, 1: request accepted this cycle.
- out_data, out, FIELD_W: extracted field, right-aligned.
- out_valid, out, 1: out_data valid.
- out_ready, in, 1: consumer takes out_data.
- fill, out, $clog2(BUF_W+1): current buffer occupancy in bits.
- err_len, out, 1: one-cycle pulse on an illegal req_len.

Behaviour:
- Reset or flush, both synchronous:
  - fill = 0, hold register empty, token index = 0, extractor FSM = IDLE.
  - out_valid = 0, out_data = 0, err_len = 0.
  - rst and flush have identical effect. Both take priority over any same-cycle handshake; a word or request presented in that cycle is dropped.
- Input hold:
  - in_ready = hold_empty OR (last non-stalled token being appended this cycle).
  - On in_valid & in_ready, the word is loaded and the token index is set to 0.
- Token expansion, one token per cycle, tokens 0..NTOK-1 in order:
  - A token with run r appends r copies of its bit value.
  - r = 0 is padding: it appends nothing and still consumes its cycle.
  - Append occurs only if fill + r <= BUF_W, using fill before any same-cycle extraction. Otherwise the token stalls and is retried every cycle.
  - After the last token, the hold register is empty unless a new word loaded in the same cycle.
  - Minimum word latency: load cycle, then NTOK cycles of expansion.
- Bit ordering: FIFO, oldest bit first. The oldest bit becomes the MSB of the extracted field.
- Extractor FSM:
  - IDLE: req_ready = 1. On req_valid:
    - If req_len == 0 or req_len > FIELD_W: pulse err_len, drop the request, stay in IDLE.
    - Otherwise latch len and signed, go to WAIT.
  - WAIT: req_ready = 0. When fill >= len:
    - Remove the len oldest bits.
    - out_data = those bits right-aligned, upper bits = signed ? field MSB : 0.
    - Go to VALID. out_valid rises the next cycle.
  - VALID: out_valid = 1 and out_data held stable until out_ready. On out_valid & out_ready, go to IDLE; out_valid = 0 the next cycle.
  - Latency: a request with sufficient fill gives out_valid 2 cycles after the req_valid & req_ready cycle.
- Simultaneous append and extract in one cycle:
  - New fill = fill + r - len.
  - Appended bits go behind the existing bits; extraction always takes bits that were present before the cycle.
- fill is never allowed to exceed BUF_W.
- No deadlock is possible under the BUF_W parameter constraint: when fill >= FIELD_W, any pending request is served.

Test Plan:
- Reset then decode:
  - Send in_data = 32'hF3C4_0000 (DATA_W=32, RUN_W=3); fill reaches 18 after 8 expansion cycles.
  - Request len 16, unsigned -> out_data = 16'hFE3C, fill = 2.
  - Request len 2 -> out_data = 16'h0000, fill = 0.
- Sign extension:
  - Send 32'hE000_0000 (bit1 run6); request len 6 signed -> 16'hFFFF.
  - Same stimulus after reset, unsigned -> 16'h003F.
- Starvation:
  - Request len 16 with fill = 0 -> FSM in WAIT, out_valid = 0.
  - Then send 32'hFF00_0000 (14 bits) -> still waiting.
  - Then 32'h9A00_0000 (3 more bits) -> out_valid with 16'hFFFF, fill = 1.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles -> out_data stable, req_ready = 0.
  - Stream words of 8 x 16'h...F tokens (56 bits each) -> in_ready drops and tokens stall at fill 128 with no overflow.
  - Release out_ready -> the stall clears and no bits are lost: the concatenated stream is checked against a model.
- Illegal length: req_len = 0 and req_len = 17 -> err_len one-cycle pulse each time, FSM remains IDLE, fill unchanged.
- Flush mid-operation: assert flush while in VALID with fill = 40 and the hold register half-expanded -> next cycle fill = 0, out_valid = 0, in_ready = 1, req_ready = 1.
